// File: rtl/rr_grant_sched6.sv
// Six-way round-robin arbiter with registered one-hot grant, owner index and
// per-grant hold timeout; a GAP cycle separates consecutive owners.
module rr_grant_sched6 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  req,
    input  logic        done,
    output logic [5:0]  grant,
    output logic [2:0]  grant_idx,
    output logic        busy,
    output logic        timeout
);

    localparam int unsigned NREQ = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    state_t              state;
    logic [2:0]          ptr;
    logic [HOLD_W-1:0]   hold_cnt;

    logic [7:0]          req_ext;
    logic [2:0]          win_c;
    logic                found_c;
    logic                drop_c;
    logic                hold_hit_c;
    logic                exit_c;
    logic [2:0]          ptr_next_c;

    // Padded so a 3-bit index can never select outside the vector.
    assign req_ext = {2'b00, req};

    // First requester at or after ptr, wrapping 5 -> 0.
    always_comb begin
        logic [3:0] cand;
        win_c   = 3'd0;
        found_c = 1'b0;
        cand    = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            cand = 4'({1'b0, ptr}) + 4'(i);
            if (cand >= 4'd6) begin
                cand = cand - 4'd6;
            end
            if (!found_c && req_ext[cand[2:0]]) begin
                found_c = 1'b1;
                win_c   = cand[2:0];
            end
        end
    end

    assign drop_c     = !req_ext[grant_idx];
    assign hold_hit_c = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));
    assign exit_c     = done || drop_c || hold_hit_c;
    assign ptr_next_c = (grant_idx == 3'd5) ? 3'd0 : grant_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 6'd0;
            grant_idx <= 3'd0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found_c) begin
                        state     <= GRANT;
                        grant_idx <= win_c;
                        grant     <= 6'd1 << win_c;
                        busy      <= 1'b1;
                        hold_cnt  <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (exit_c) begin
                        state   <= GAP;
                        grant   <= 6'd0;
                        busy    <= 1'b0;
                        ptr     <= ptr_next_c;
                        // Only a pure hold expiry counts as a revoke.
                        timeout <= hold_hit_c && !done && !drop_c;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_sched6.sv
// Scenario bench for rr_grant_sched6: expected owners are queued when requests
// are driven and compared as each new grant appears.
module tb_rr_grant_sched6;

    logic       clk;
    logic       rst;
    logic [5:0] req;
    logic       done;
    logic [5:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       timeout;

    int checks;
    int failures;
    bit mon_en;
    logic [2:0] exp_q[$];

    rr_grant_sched6 #(.MAX_HOLD(16), .HOLD_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 6'd0;
        done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Structural invariants checked every cycle away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((grant !== (busy ? (6'd1 << grant_idx) : 6'd0)) || (grant_idx > 3'd5)) begin
                failures++;
                $display("FAIL invariant: grant=%b busy=%b grant_idx=%0d", grant, busy, grant_idx);
            end
        end
    end

    task automatic test_reset();
        rst  = 1'b1;
        req  = 6'h3F;
        done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) rst = 1'b0;
            checks++;
            if ({grant, grant_idx, busy, timeout} !== 11'd0) begin
                failures++;
                $display("FAIL reset_c%0d: grant=%b idx=%0d busy=%b timeout=%b want all 0",
                         c, grant, grant_idx, busy, timeout);
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        logic [2:0] e;
        do_reset();
        req = 6'b000100;
        exp_q.push_back(3'd2);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (grant !== 6'b000100 || grant_idx !== e || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_first: grant=%b idx=%0d busy=%b want 000100/%0d/1", grant, grant_idx, busy, e);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 6'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release: grant=%b busy=%b want 0/0", grant, busy);
        end
        exp_q.push_back(3'd2);
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: busy=%b want 0", busy);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (grant !== 6'b000100 || grant_idx !== e || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_regrant: grant=%b idx=%0d busy=%b want 000100/%0d/1", grant, grant_idx, busy, e);
        end
        req = 6'd0;
        tick();
        tick();
    endtask

    task automatic test_fairness();
        logic [2:0] e;
        logic [5:0] eg;
        int n;
        do_reset();
        req = 6'h3F;
        for (int g = 0; g < 8; g++) exp_q.push_back(3'(g % 6));
        for (int g = 0; g < 8; g++) begin
            n = 0;
            while (!busy && n < 6) begin
                tick();
                n++;
            end
            e  = exp_q.pop_front();
            eg = 6'd1 << e;
            checks++;
            if (busy !== 1'b1 || grant_idx !== e || grant !== eg) begin
                failures++;
                $display("FAIL fair_g%0d: busy=%b idx=%0d grant=%b want 1/%0d/%b", g, busy, grant_idx, grant, e, eg);
            end
            checks++;
            if (n != ((g == 0) ? 1 : 2)) begin
                failures++;
                $display("FAIL fair_latency_g%0d: edges=%0d want %0d", g, n, (g == 0) ? 1 : 2);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (grant !== 6'd0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL fair_gap_g%0d: grant=%b busy=%b want 0/0", g, grant, busy);
            end
        end
        req = 6'd0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        logic [2:0] e;
        int cyc;
        bit early_to;
        do_reset();
        req = 6'b100001;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd5);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b1 || grant_idx !== e) begin
            failures++;
            $display("FAIL to_first: busy=%b idx=%0d want 1/%0d", busy, grant_idx, e);
        end
        cyc = 0;
        early_to = 1'b0;
        while (busy && cyc < 40) begin
            if (timeout) early_to = 1'b1;
            cyc++;
            tick();
        end
        checks++;
        if (cyc != 16 || early_to) begin
            failures++;
            $display("FAIL to_hold: held=%0d early_timeout=%0d want 16/0", cyc, early_to);
        end
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL to_pulse: timeout=%b busy=%b want 1/0", timeout, busy);
        end
        tick();
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL to_clear: timeout=%b busy=%b want 0/0", timeout, busy);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b1 || grant_idx !== e || grant !== 6'b100000) begin
            failures++;
            $display("FAIL to_next: busy=%b idx=%0d grant=%b want 1/%0d/100000", busy, grant_idx, grant, e);
        end
        req = 6'd0;
        tick();
        tick();
    endtask

    task automatic test_done_drop();
        logic [2:0] e;
        do_reset();
        req = 6'b011000;
        exp_q.push_back(3'd3);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b1 || grant_idx !== e) begin
            failures++;
            $display("FAIL dd_owner: busy=%b idx=%0d want 1/%0d", busy, grant_idx, e);
        end
        req  = 6'b010001;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b0 || grant !== 6'd0) begin
            failures++;
            $display("FAIL dd_exit: timeout=%b busy=%b grant=%b want 0/0/0", timeout, busy, grant);
        end
        exp_q.push_back(3'd4);
        tick();
        tick();
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b1 || grant_idx !== e || grant !== 6'b010000) begin
            failures++;
            $display("FAIL dd_next: busy=%b idx=%0d grant=%b want 1/%0d/010000", busy, grant_idx, grant, e);
        end
        req = 6'd0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        logic [2:0] e;
        do_reset();
        req = 6'b010000;
        exp_q.push_back(3'd4);
        tick();
        tick();
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b1 || grant_idx !== e) begin
            failures++;
            $display("FAIL rm_owner: busy=%b idx=%0d want 1/%0d", busy, grant_idx, e);
        end
        rst = 1'b1;
        req = 6'h30;
        tick();
        rst = 1'b0;
        checks++;
        if (grant !== 6'd0 || busy !== 1'b0 || grant_idx !== 3'd0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL rm_reset: grant=%b busy=%b idx=%0d timeout=%b want 0/0/0/0",
                     grant, busy, grant_idx, timeout);
        end
        exp_q.push_back(3'd4);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b1 || grant_idx !== e || grant !== 6'b010000) begin
            failures++;
            $display("FAIL rm_after: busy=%b idx=%0d grant=%b want 1/%0d/010000", busy, grant_idx, grant, e);
        end
        req = 6'd0;
        tick();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        req      = 6'd0;
        done     = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_done_drop();
        test_reset_mid_grant();
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
